bp_stall_counter_sampler: RTL and testbench
===========================================

# bp_stall_counter_sampler

Controls the stall/instruction counter bank over fixed-length sampling windows. It gates the bank's count enable, clears it between windows, and snapshots all counters into a shadow buffer at each window boundary. The shadow buffer drains to the host as a ready/valid word stream: a sequence-number header followed by every counter. It sits between the profiler counter bank (driving its `en_i`/`freeze_i`) and the host CSR/FIFO shell.

## Interface
- `width_p`, 32: width of each counter and of every stream word.
- `num_counters_p`, 32: number of counters in the bank.
- `period_width_p`, 32: width of the window-length configuration.
- `clk_i` in 1: clock.
- `reset_i` in 1: reset, asynchronous and active-high.
- `cfg_period_i` in `period_width_p`: window length P in cycles, sampled at start and at each reload. P=0 means windows end only on stop.
- `cfg_oneshot_i` in 1: sampled on start. If 1, stop after the first snapshot.
- `cfg_start_i` in 1: start pulse. Ignored unless in IDLE.
- `cfg_stop_i` in 1: stop pulse. Ignored in IDLE.
- `counters_i` in `num_counters_p*width_p`: counter bank outputs. Counter k is at bits [k*width_p +: width_p].
- `en_o` out 1: count enable to the bank.
- `clear_o` out 1: synchronous clear to the bank.
- `data_o` out `width_p`: stream word.
- `v_o` out 1: stream valid.
- `ready_i` in 1: stream ready. A transfer happens when `v_o & ready_i`.
- `busy_o` out 1: high when state != IDLE or the shadow buffer holds data.
- `overrun_o` out 1: sticky; a snapshot was dropped.
- `dropped_o` out `width_p`: count of dropped snapshots, saturating.

## Operation
- FSM states: IDLE, CLEAR, COUNT, SNAP.
  - IDLE: `en_o`=0, `clear_o`=0. On `cfg_start_i`: go to CLEAR; zero the sequence counter, `overrun_o` and `dropped_o`; latch oneshot.
  - CLEAR: `clear_o`=1, `en_o`=0; load timer with P; go to COUNT.
  - COUNT: `en_o`=1. Timer decrements each cycle when P≠0. Go to SNAP when (P≠0 and timer==1), or when `cfg_stop_i`, or when `stop_r` is set.
  - SNAP: `en_o`=0, `clear_o`=1; reload timer with P; increment the sequence number. Go to IDLE if `stop_r`, `cfg_stop_i` or oneshot is set; otherwise go to COUNT.
- `stop_r`: set by `cfg_stop_i` in CLEAR or SNAP; cleared on entry to IDLE.
- `en_o` and `clear_o` are never both high.
- Capture in SNAP: `counters_i` loads into the shadow buffer and the current sequence number into the header register. This happens only if the shadow buffer is empty, or if its last word transfers in this same cycle.
  - Otherwise the snapshot is dropped: the bank is still cleared, `overrun_o` is set, `dropped_o` increments (saturating at all-ones), and the sequence number still increments, so gaps are visible to the host.
- Drain: word index 0..`num_counters_p`.
  - Index 0 sends the header; index i sends counter i-1.
  - Index advances on each transfer. A transfer at index `num_counters_p` empties the shadow buffer and resets the index to 0.
  - `data_o` is stable while `v_o & ~ready_i`.
- The drain runs concurrently with COUNT. It continues after the FSM returns to IDLE.
- A start issued in IDLE while a drain is pending is legal. The pending snapshot keeps its own header.
- Reset: all state is cleared asynchronously. IDLE; `en_o`, `clear_o`, `v_o`, `busy_o`, `overrun_o` = 0; `dropped_o`, `data_o`, sequence number and index = 0; any buffered snapshot is discarded.

## Timing
- Start pulse in cycle t:
  - CLEAR in t+1.
  - `en_o` high in t+2 .. t+P+1 (exactly P cycles).
  - SNAP in t+P+2.
- `counters_i` sampled in SNAP reflects all P enabled cycles (bank outputs are registered).
- `v_o` rises in the cycle after SNAP, with header = window sequence number (first window = 0).
- Back-to-back windows: each window is P COUNT cycles plus 1 SNAP cycle, so period = P+1.
- Draining needs `num_counters_p`+1 transfers. If `ready_i` is held high and P+1 ≥ `num_counters_p`+1, no drops occur.
- Stop asserted in COUNT: SNAP in the next cycle (partial window), then IDLE.
- Stop and timer expiry in the same cycle: a single SNAP, then IDLE.

## Test plan
- N=4, P=10, bank increments on `en_o`, `ready_i`=1, oneshot. Start → `en_o` high for 10 cycles; stream is 0,10,10,10,10; IDLE; `busy_o` falls after the last word.
- Continuous, N=4, P=10, `ready_i`=1. → Headers 0,1,2… with every counter word = 10; `overrun_o`=0.
- Continuous, N=4, P=3, `ready_i` low for 20 cycles. → First snapshot held; subsequent SNAPs dropped; `overrun_o`=1; `dropped_o` equals the skipped headers; the next header shows the gap.
- P=0; start; stop after 7 cycles in COUNT. → One snapshot, counters=7, header 0, then IDLE.
- Last drain word accepted in the same cycle as SNAP. → New snapshot captured, no drop.
- Assert `reset_i` mid-drain with `v_o`=1. → Outputs zero immediately; a subsequent start yields header 0.

Source files
------------

// File: rtl/bp_stall_counter_sampler.sv
// Sampling-window controller for the profiler counter bank.
// Gates/clears the bank, snapshots it per window and drains it as a word stream.
module bp_stall_counter_sampler #(
    parameter int width_p        = 32,
    parameter int num_counters_p = 32,
    parameter int period_width_p = 32
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [period_width_p-1:0]         cfg_period_i,
    input  logic                              cfg_oneshot_i,
    input  logic                              cfg_start_i,
    input  logic                              cfg_stop_i,
    input  logic [num_counters_p*width_p-1:0] counters_i,
    output logic                              en_o,
    output logic                              clear_o,
    output logic [width_p-1:0]                data_o,
    output logic                              v_o,
    input  logic                              ready_i,
    output logic                              busy_o,
    output logic                              overrun_o,
    output logic [width_p-1:0]                dropped_o
);

    localparam logic [1:0] idle_s  = 2'd0;
    localparam logic [1:0] clear_s = 2'd1;
    localparam logic [1:0] count_s = 2'd2;
    localparam logic [1:0] snap_s  = 2'd3;

    localparam int words_lp = num_counters_p + 1;
    localparam int idx_w_lp = $clog2(words_lp);
    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(num_counters_p);

    logic [1:0]                state_r, state_n;
    logic [period_width_p-1:0] timer_r, period_r;
    logic [width_p-1:0]        seq_r, dropped_r;
    logic                      oneshot_r, stop_r, overrun_r, full_r;
    logic [idx_w_lp-1:0]       idx_r;
    logic [width_p-1:0]        shadow_r [words_lp];

    logic snap, xfer, xfer_last, capture, drop, expire, finish;

    assign snap      = (state_r == snap_s);
    assign xfer      = full_r & ready_i;
    assign xfer_last = xfer & (idx_r == last_idx_lp);
    // A snapshot may reuse the buffer when its final word leaves this cycle
    assign capture   = snap & (~full_r | xfer_last);
    assign drop      = snap & ~capture;
    assign expire    = (period_r != '0) && (timer_r == period_width_p'(1));
    assign finish    = stop_r | cfg_stop_i | oneshot_r;

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            idle_s:  if (cfg_start_i) state_n = clear_s;
            clear_s: state_n = count_s;
            count_s: if (expire | cfg_stop_i | stop_r) state_n = snap_s;
            snap_s:  state_n = finish ? idle_s : count_s;
            default: state_n = idle_s;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= idle_s;
            timer_r   <= '0;
            period_r  <= '0;
            seq_r     <= '0;
            dropped_r <= '0;
            oneshot_r <= 1'b0;
            stop_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r <= state_n;
            if (state_r == idle_s && cfg_start_i) begin
                seq_r     <= '0;
                overrun_r <= 1'b0;
                dropped_r <= '0;
                oneshot_r <= cfg_oneshot_i;
            end
            if (state_r == clear_s || snap) begin
                timer_r  <= cfg_period_i;
                period_r <= cfg_period_i;
            end else if (state_r == count_s && period_r != '0) begin
                timer_r <= timer_r - 1'b1;
            end
            // Any stop while running ends the run after the next snapshot
            if (state_n == idle_s) stop_r <= 1'b0;
            else if (cfg_stop_i && state_r != idle_s) stop_r <= 1'b1;
            if (snap) seq_r <= seq_r + 1'b1;
            if (drop) begin
                overrun_r <= 1'b1;
                if (dropped_r != '1) dropped_r <= dropped_r + 1'b1;
            end
        end
    end

    // Shadow buffer drains by shifting; word 0 is always the one on the bus
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            full_r <= 1'b0;
            idx_r  <= '0;
            for (int k = 0; k < words_lp; k++) shadow_r[k] <= '0;
        end else if (capture) begin
            full_r      <= 1'b1;
            idx_r       <= '0;
            shadow_r[0] <= seq_r;
            for (int k = 0; k < num_counters_p; k++)
                shadow_r[k+1] <= counters_i[k*width_p +: width_p];
        end else if (xfer) begin
            for (int k = 0; k < words_lp - 1; k++) shadow_r[k] <= shadow_r[k+1];
            if (xfer_last) begin
                full_r <= 1'b0;
                idx_r  <= '0;
            end else begin
                idx_r <= idx_r + 1'b1;
            end
        end
    end

    assign en_o      = (state_r == count_s);
    assign clear_o   = (state_r == clear_s) | snap;
    assign v_o       = full_r;
    assign data_o    = shadow_r[0];
    assign busy_o    = (state_r != idle_s) | full_r;
    assign overrun_o = overrun_r;
    assign dropped_o = dropped_r;

endmodule

// File: tb/tb_bp_stall_counter_sampler.sv
// Bench for bp_stall_counter_sampler: window-level reference model,
// a modelled counter bank, directed scenarios plus randomized traffic.
module tb_bp_stall_counter_sampler;

    localparam int W = 32;
    localparam int N = 4;
    localparam int PW = 32;

    logic clk_i = 0;
    logic reset_i;
    logic [PW-1:0] cfg_period_i;
    logic cfg_oneshot_i, cfg_start_i, cfg_stop_i, ready_i;
    logic [N*W-1:0] counters_i;
    logic en_o, clear_o, v_o, busy_o, overrun_o;
    logic [W-1:0] data_o, dropped_o;

    bp_stall_counter_sampler #(
        .width_p(W), .num_counters_p(N), .period_width_p(PW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cfg_period_i(cfg_period_i), .cfg_oneshot_i(cfg_oneshot_i),
        .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i),
        .counters_i(counters_i), .en_o(en_o), .clear_o(clear_o),
        .data_o(data_o), .v_o(v_o), .ready_i(ready_i), .busy_o(busy_o),
        .overrun_o(overrun_o), .dropped_o(dropped_o)
    );

    always #5 clk_i = ~clk_i;

    // Environment: counter k adds k+1 per enabled cycle, registered outputs
    logic [W-1:0] bank [N];
    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < N; k++) bank[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++)
                if (clear_o) bank[k] <= '0;
                else if (en_o) bank[k] <= bank[k] + W'(k + 1);
        end
    end
    always_comb begin
        counters_i = '0;
        for (int k = 0; k < N; k++) counters_i[k*W +: W] = bank[k];
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model in window terms: running flag, boundary cycle
    // (clear or snapshot), enabled cycles so far, and the expected stream.
    bit m_run, m_bnd, m_first, m_one, m_stop, m_ovr;
    int m_cnt;
    logic [W-1:0] m_per, m_seq, m_drop;
    logic [W-1:0] mq[$];

    task automatic model_reset();
        m_run = 0; m_bnd = 0; m_first = 0; m_one = 0; m_stop = 0;
        m_ovr = 0; m_cnt = 0; m_per = 0; m_seq = 0; m_drop = 0;
        mq.delete();
    endtask

    task automatic model_step();
        if (mq.size() > 0 && ready_i) void'(mq.pop_front());
        if (!m_run) begin
            if (cfg_start_i) begin
                m_run = 1; m_bnd = 1; m_first = 1; m_stop = 0;
                m_seq = 0; m_ovr = 0; m_drop = 0; m_one = cfg_oneshot_i;
            end
        end else if (m_bnd) begin
            if (cfg_stop_i) m_stop = 1;
            if (!m_first) begin
                if (mq.size() == 0) begin
                    mq.push_back(m_seq);
                    for (int k = 0; k < N; k++) mq.push_back(W'((k + 1) * m_cnt));
                end else begin
                    m_ovr = 1;
                    if (m_drop != '1) m_drop++;
                end
                m_seq++;
                if (m_stop || m_one) begin
                    m_run = 0; m_stop = 0;
                end
            end
            m_first = 0; m_cnt = 0; m_bnd = 0; m_per = cfg_period_i;
        end else begin
            m_cnt++;
            if (cfg_stop_i) m_stop = 1;
            if ((m_per != 0 && m_cnt == int'(m_per)) || m_stop) m_bnd = 1;
        end
    endtask

    task automatic check_outputs();
        check("en", en_o, m_run && !m_bnd);
        check("clear", clear_o, m_run && m_bnd);
        check("v", v_o, mq.size() > 0);
        check("busy", busy_o, m_run || mq.size() > 0);
        check("overrun", overrun_o, m_ovr);
        check("dropped", dropped_o, m_drop);
        if (mq.size() > 0) check("data", data_o, mq[0]);
    endtask

    task automatic step();
        @(posedge clk_i);
        if (reset_i) model_reset();
        else model_step();
        #1 check_outputs();
    endtask

    task automatic run(input int n, input int pct);
        for (int i = 0; i < n; i++) begin
            ready_i = ($urandom_range(0, 99) < pct);
            step();
        end
    endtask

    task automatic pulse_start();
        cfg_start_i = 1; step(); cfg_start_i = 0;
    endtask

    task automatic pulse_stop();
        cfg_stop_i = 1; step(); cfg_stop_i = 0;
    endtask

    initial begin
        reset_i = 1; cfg_period_i = 0; cfg_oneshot_i = 0;
        cfg_start_i = 0; cfg_stop_i = 0; ready_i = 0;
        model_reset();
        step(); step();
        check("rst_data", data_o, 0);
        reset_i = 0;
        run(2, 100);

        // oneshot window of 10
        cfg_period_i = 10; cfg_oneshot_i = 1;
        pulse_start(); run(40, 100);

        // continuous windows, full-rate drain
        cfg_oneshot_i = 0;
        pulse_start(); run(60, 100); pulse_stop(); run(20, 100);

        // short windows while the host stalls: drops and sequence gaps
        cfg_period_i = 3;
        pulse_start(); run(20, 0); run(40, 100); pulse_stop(); run(20, 100);

        // open-ended window closed by stop after 7 enabled cycles
        cfg_period_i = 0;
        pulse_start(); run(7, 100); pulse_stop(); run(20, 100);

        // last drain word coincides with every snapshot
        cfg_period_i = 4;
        pulse_start(); run(40, 100); pulse_stop(); run(20, 100);

        // reset mid-drain, then a fresh run starts at header 0
        cfg_period_i = 2; cfg_oneshot_i = 1;
        pulse_start(); run(6, 0);
        check("pre_rst_v", v_o, 1);
        reset_i = 1;
        #1;
        check("rst_v", v_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_en", en_o, 0);
        check("rst_data2", data_o, 0);
        model_reset();
        step(); step();
        reset_i = 0;
        pulse_start(); run(20, 100);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cfg_start_i = ($urandom_range(0, 19) == 0);
            cfg_stop_i = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) cfg_period_i = $urandom_range(0, 9);
            cfg_oneshot_i = ($urandom_range(0, 3) == 0);
            ready_i = ($urandom_range(0, 99) < 70);
            step();
        end
        cfg_start_i = 0;
        pulse_stop(); run(40, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
